bcd_counter_mod: RTL and testbench
==================================

// Module: bcd_counter_mod
// PURPOSE
//  Parametrised N-digit BCD modulo counter with up/down, synchronous load and terminal-count carry.
//  Generalises the fixed 2-digit 00..99 stage into one block for the digital clock.
//  Sub-second, second, minute and hour stages all use it, cascaded through carry -> en.
//  Load provides time-set; down mode provides countdown/timer.
// PARAMETERS
//  DIGITS   2      number of BCD digits; cnt_bcd width = 4*DIGITS; legal range 1..8
//  MAX_BCD  8'h59  terminal value, BCD-coded, 4*DIGITS bits; count range is 0..MAX_BCD
//                  (8'h59 = sec/min, 8'h23 = hour, 8'h99 = centisec).
//                  Every nibble must be <=9; elaboration fails otherwise.
// PORTS
//  clk_100Hz  in   1          system clock; all state updates on rising edge
//  rst        in   1          synchronous reset, active-high
//  en         in   1          count enable; one step per clock while high
//  up_dn      in   1          1 = count up, 0 = count down; sampled each cycle
//  load       in   1          synchronous load of load_val; overrides en
//  load_val   in   4*DIGITS   BCD value to load
//  cnt_bcd    out  4*DIGITS   current count, BCD; nibble k = decimal digit k (LSD at [3:0])
//  carry      out  1          combinational; terminal-count step in progress
//  load_err   out  1          registered; 1-cycle pulse when a load is rejected
// BEHAVIOUR
//  - Priority, evaluated at each rising clk_100Hz edge: rst > load > en > hold.
//  - rst=1: cnt_bcd <= 0, load_err <= 0. Overrides load/en; reset mid-count just restarts from 0.
//  - load=1, load_val valid: cnt_bcd <= load_val next cycle; no count step that cycle.
//    Valid means every nibble <=9 AND load_val <= MAX_BCD (BCD order == binary order when valid).
//    load_err <= 0.
//  - load=1, load_val invalid: cnt_bcd <= 0, load_err <= 1 for exactly one cycle.
//  - en=1, up_dn=1:
//    - cnt_bcd==MAX_BCD -> 0.
//    - Otherwise BCD +1: digit k increments when all lower digits==9; those lower digits become 0.
//  - en=1, up_dn=0:
//    - cnt_bcd==0 -> MAX_BCD.
//    - Otherwise BCD -1: digit k decrements when all lower digits==0; those lower digits become 9.
//  - en=0, load=0: cnt_bcd holds.
//  - load_err is 0 in every cycle except the one following a rejected load.
//  - carry = en & ~load & ~rst & (up_dn ? cnt_bcd==MAX_BCD : cnt_bcd==0).
//    - Purely combinational: high during the cycle whose edge wraps the counter.
//    - Feeds the next stage's en, so the cascade advances on the same edge with zero-cycle latency.
//  - Per-digit carries are internal; digits never show values >9 or pass through an
//    intermediate value visible on cnt_bcd.
//  - up_dn may change any cycle; the new direction applies on the next enabled edge.
//    No extra latency on direction change.
//  - DIGITS=1 degenerates to a single-nibble mod-(MAX_BCD+1) counter.
//  - MAX_BCD=0: the counter stays at 0 and carry = en whenever enabled.
// TESTING
//  1. DIGITS=2, MAX=8'h59, up, en=1 for 61 clk from rst -> 00..59,00,01;
//     carry high only while cnt=59; 09->10 and 49->50 ripple correct.
//  2. Down, en=1 from cnt=8'h01 -> 00 then 59, 58;
//     carry high only while cnt=00; 10->09 borrow correct.
//  3. load=1, load_val=8'h37, en=1 -> cnt=37 next cycle (no +1), load_err=0;
//     then en=0 for 5 clk -> holds 37, carry=0.
//  4. load_val=8'h6A, then load_val=8'h60 (both invalid) ->
//     cnt=00, load_err pulses 1 cycle each time.
//  5. Counting up at 8'h42: assert rst with load=1, en=1 -> cnt=00, load_err=0 next cycle;
//     counting resumes from 00 after rst drops.
//  6. DIGITS=3, MAX=12'h999, load 12'h099 then en, up -> 100;
//     load 12'h999, en -> 000 with carry=1; down from 000 -> 999.
//  7. DIGITS=2, MAX=8'h23, up -> 23 -> 00 with carry at 23.
//     Cascade two instances (sec->min) -> min increments on the sec 59->00 edge.

Source files
------------

// File: rtl/bcd_counter_mod.sv
// ============================================================================
//  Module      : bcd_counter_mod
//  Description : N-digit BCD modulo counter (0..MAX_BCD) with up/down count,
//                synchronous validated load and a combinational terminal-count
//                carry that drives the enable of the next cascaded stage.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module bcd_counter_mod #(
    parameter int                  DIGITS  = 2,
    parameter logic [4*DIGITS-1:0] MAX_BCD = 8'h59
) (
    input  logic                  clk_100Hz,
    input  logic                  rst,
    input  logic                  en,
    input  logic                  up_dn,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   load_val,
    output logic [4*DIGITS-1:0]   cnt_bcd,
    output logic                  carry,
    output logic                  load_err
);

    localparam int c_width = 4 * DIGITS;

    // ------------------------------------------------------------------------
    // Elaboration-time parameter sanity checks
    // ------------------------------------------------------------------------
    if (DIGITS < 1 || DIGITS > 8) begin : g_bad_digits
        $error("bcd_counter_mod: DIGITS must be in 1..8");
    end

    for (genvar g = 0; g < DIGITS; g++) begin : g_max_check
        if (MAX_BCD[4*g +: 4] > 4'd9) begin : g_bad_nibble
            $error("bcd_counter_mod: MAX_BCD contains a non-BCD nibble");
        end
    end

    // ------------------------------------------------------------------------
    // Signals
    // ------------------------------------------------------------------------
    logic [c_width-1:0] cnt_q;
    logic [c_width-1:0] cnt_d;
    logic               load_err_q;
    logic               load_err_d;

    logic [c_width-1:0] w_step;      // count +/-1 ignoring the wrap points
    logic               w_ripple;    // every lower digit sits at its rollover value
    logic [3:0]         w_digit;
    logic               w_load_ok;
    logic               w_at_max;
    logic               w_at_zero;

    assign w_at_max  = (cnt_q == MAX_BCD);
    assign w_at_zero = (cnt_q == '0);

    // A load is accepted only if every nibble is a decimal digit and the value
    // lies inside the count range (BCD order matches binary order once valid).
    always_comb begin
        w_load_ok = (load_val <= MAX_BCD);
        for (int k = 0; k < DIGITS; k++) begin
            if (load_val[4*k +: 4] > 4'd9) begin
                w_load_ok = 1'b0;
            end
        end
    end

    // Per-digit BCD increment/decrement; a digit moves only when all lower
    // digits roll over (9->0 going up, 0->9 going down).
    always_comb begin
        w_step   = cnt_q;
        w_ripple = 1'b1;
        w_digit  = 4'd0;
        for (int k = 0; k < DIGITS; k++) begin
            w_digit = cnt_q[4*k +: 4];
            if (w_ripple) begin
                if (up_dn) begin
                    w_step[4*k +: 4] = (w_digit == 4'd9) ? 4'd0 : w_digit + 4'd1;
                end else begin
                    w_step[4*k +: 4] = (w_digit == 4'd0) ? 4'd9 : w_digit - 4'd1;
                end
            end
            w_ripple = w_ripple & (up_dn ? (w_digit == 4'd9) : (w_digit == 4'd0));
        end
    end

    // Next-state selection: load beats count enable, otherwise hold.
    always_comb begin
        cnt_d      = cnt_q;
        load_err_d = 1'b0;
        if (load) begin
            if (w_load_ok) begin
                cnt_d = load_val;
            end else begin
                cnt_d      = '0;
                load_err_d = 1'b1;
            end
        end else if (en) begin
            if (up_dn) begin
                cnt_d = w_at_max ? '0 : w_step;
            end else begin
                cnt_d = w_at_zero ? MAX_BCD : w_step;
            end
        end
    end

    // State register with synchronous reset taking priority over everything.
    always_ff @(posedge clk_100Hz) begin
        if (rst) begin
            cnt_q      <= '0;
            load_err_q <= 1'b0;
        end else begin
            cnt_q      <= cnt_d;
            load_err_q <= load_err_d;
        end
    end

    // Carry is combinational so the next stage steps on the same edge as the wrap.
    assign carry    = en & ~load & ~rst & (up_dn ? w_at_max : w_at_zero);
    assign cnt_bcd  = cnt_q;
    assign load_err = load_err_q;

endmodule

`default_nettype wire

// File: tb/tb_bcd_counter_mod.sv
// ============================================================================
//  Module      : tb_bcd_counter_mod
//  Description : Self-checking bench for bcd_counter_mod: sec/min, 3-digit,
//                hour, cascaded and MAX_BCD=0 instances.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_bcd_counter_mod;

    logic clk;
    logic rst;

    // Main 2-digit mod-60 instance
    logic       m_en, m_up, m_ld;
    logic [7:0] m_lv, m_cnt;
    logic       m_carry, m_err;

    // 3-digit mod-1000 instance
    logic        t_en, t_up, t_ld;
    logic [11:0] t_lv, t_cnt;
    logic        t_carry, t_err;

    // 2-digit mod-24 instance
    logic       h_en, h_up, h_ld;
    logic [7:0] h_lv, h_cnt;
    logic       h_carry, h_err;

    // Cascade sec -> min
    logic       c_up;
    logic       s_en, s_ld, n_ld;
    logic [7:0] s_lv, s_cnt, n_lv, n_cnt;
    logic       s_carry, s_err, n_carry, n_err;

    // 1-digit MAX_BCD=0 instance
    logic       z_en, z_up, z_ld;
    logic [3:0] z_lv, z_cnt;
    logic       z_carry, z_err;

    int checks   = 0;
    int failures = 0;

    bcd_counter_mod #(.DIGITS(2), .MAX_BCD(8'h59)) u_main (
        .clk_100Hz(clk), .rst(rst), .en(m_en), .up_dn(m_up), .load(m_ld),
        .load_val(m_lv), .cnt_bcd(m_cnt), .carry(m_carry), .load_err(m_err));

    bcd_counter_mod #(.DIGITS(3), .MAX_BCD(12'h999)) u_d3 (
        .clk_100Hz(clk), .rst(rst), .en(t_en), .up_dn(t_up), .load(t_ld),
        .load_val(t_lv), .cnt_bcd(t_cnt), .carry(t_carry), .load_err(t_err));

    bcd_counter_mod #(.DIGITS(2), .MAX_BCD(8'h23)) u_hr (
        .clk_100Hz(clk), .rst(rst), .en(h_en), .up_dn(h_up), .load(h_ld),
        .load_val(h_lv), .cnt_bcd(h_cnt), .carry(h_carry), .load_err(h_err));

    bcd_counter_mod #(.DIGITS(2), .MAX_BCD(8'h59)) u_sec (
        .clk_100Hz(clk), .rst(rst), .en(s_en), .up_dn(c_up), .load(s_ld),
        .load_val(s_lv), .cnt_bcd(s_cnt), .carry(s_carry), .load_err(s_err));

    bcd_counter_mod #(.DIGITS(2), .MAX_BCD(8'h59)) u_min (
        .clk_100Hz(clk), .rst(rst), .en(s_carry), .up_dn(c_up), .load(n_ld),
        .load_val(n_lv), .cnt_bcd(n_cnt), .carry(n_carry), .load_err(n_err));

    bcd_counter_mod #(.DIGITS(1), .MAX_BCD(4'h0)) u_zero (
        .clk_100Hz(clk), .rst(rst), .en(z_en), .up_dn(z_up), .load(z_ld),
        .load_val(z_lv), .cnt_bcd(z_cnt), .carry(z_carry), .load_err(z_err));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Vector record: ctl = {rst, en, up_dn, load}; flags = {carry, load_err}
    typedef struct {
        logic [3:0] ctl;
        logic [7:0] lv;
        logic [7:0] cnt;
        logic [1:0] flags;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic [3:0] ctl, input logic [7:0] lv,
                       input logic [7:0] cnt, input logic [1:0] flags);
        vec_t v;
        v.ctl = ctl; v.lv = lv; v.cnt = cnt; v.flags = flags;
        vecs.push_back(v);
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [7:0] to_bcd(input int v);
        return 8'(((v / 10) << 4) | (v % 10));
    endfunction

    initial begin
        rst = 1'b1;
        m_en = 0; m_up = 1; m_ld = 0; m_lv = '0;
        t_en = 0; t_up = 1; t_ld = 0; t_lv = '0;
        h_en = 0; h_up = 1; h_ld = 0; h_lv = '0;
        c_up = 1; s_en = 0; s_ld = 0; s_lv = '0; n_ld = 0; n_lv = '0;
        z_en = 0; z_up = 1; z_ld = 0; z_lv = '0;

        // ---------------- reset state ----------------
        tick();
        check("rst_main_cnt", 32'(m_cnt), 32'h00);
        check("rst_main_err", 32'(m_err), 32'h0);
        check("rst_main_carry", 32'(m_carry), 32'h0);
        check("rst_d3_cnt", 32'(t_cnt), 32'h000);
        check("rst_hr_cnt", 32'(h_cnt), 32'h00);
        rst = 1'b0;

        // ---------------- 61 up-counts from 00 ----------------
        m_en = 1; m_up = 1;
        for (int i = 0; i < 61; i++) begin
            #1;
            check($sformatf("up%0d_carry", i), 32'(m_carry), 32'((i % 60) == 59));
            tick();
            check($sformatf("up%0d_cnt", i), 32'(m_cnt), 32'(to_bcd((i + 1) % 60)));
        end

        // ---------------- directed table ----------------
        add(4'b0111, 8'h37, 8'h37, 2'b00); // load 37 with en: no extra step
        for (int i = 0; i < 5; i++) add(4'b0010, 8'h00, 8'h37, 2'b00); // hold
        add(4'b0011, 8'h6A, 8'h00, 2'b01); // invalid nibble
        add(4'b0010, 8'h00, 8'h00, 2'b00); // error pulse ends
        add(4'b0111, 8'h60, 8'h00, 2'b01); // above MAX
        add(4'b0010, 8'h00, 8'h00, 2'b00);
        add(4'b0011, 8'h42, 8'h42, 2'b00);
        add(4'b0110, 8'h00, 8'h43, 2'b00);
        add(4'b1111, 8'h55, 8'h00, 2'b00); // rst beats load and en
        add(4'b0110, 8'h00, 8'h01, 2'b00); // resumes from 00
        add(4'b0100, 8'h00, 8'h00, 2'b00); // down 01 -> 00
        add(4'b0100, 8'h00, 8'h59, 2'b10); // down wrap with carry
        add(4'b0100, 8'h00, 8'h58, 2'b00);
        add(4'b0001, 8'h10, 8'h10, 2'b00);
        add(4'b0100, 8'h00, 8'h09, 2'b00); // borrow 10 -> 09
        add(4'b0110, 8'h00, 8'h10, 2'b00); // direction change, 09 -> 10
        add(4'b0011, 8'h59, 8'h59, 2'b00);
        add(4'b0111, 8'h59, 8'h59, 2'b00); // load masks carry at MAX
        add(4'b0110, 8'h00, 8'h00, 2'b10); // up wrap with carry
        add(4'b0111, 8'h5A, 8'h00, 2'b01); // invalid low nibble
        add(4'b0101, 8'h49, 8'h49, 2'b00); // valid load right after error
        add(4'b0110, 8'h00, 8'h50, 2'b00); // 49 -> 50 ripple

        foreach (vecs[i]) begin
            {rst, m_en, m_up, m_ld} = vecs[i].ctl;
            m_lv = vecs[i].lv;
            #1;
            check($sformatf("vec%0d_carry", i), 32'(m_carry), 32'(vecs[i].flags[1]));
            tick();
            check($sformatf("vec%0d_cnt", i), 32'(m_cnt), 32'(vecs[i].cnt));
            check($sformatf("vec%0d_err", i), 32'(m_err), 32'(vecs[i].flags[0]));
        end
        rst = 0; m_en = 0; m_ld = 0;

        // ---------------- 3-digit instance ----------------
        t_ld = 1; t_lv = 12'h099; tick();
        check("d3_load099", 32'(t_cnt), 32'h099);
        t_ld = 0; t_en = 1; t_up = 1; #1;
        check("d3_carry_099", 32'(t_carry), 32'h0);
        tick();
        check("d3_up_100", 32'(t_cnt), 32'h100);
        t_up = 0; tick();
        check("d3_down_099", 32'(t_cnt), 32'h099);
        t_en = 0; t_ld = 1; t_lv = 12'h999; tick();
        check("d3_load999", 32'(t_cnt), 32'h999);
        t_ld = 0; t_en = 1; t_up = 1; #1;
        check("d3_carry_999", 32'(t_carry), 32'h1);
        tick();
        check("d3_wrap_000", 32'(t_cnt), 32'h000);
        t_up = 0; #1;
        check("d3_carry_000", 32'(t_carry), 32'h1);
        tick();
        check("d3_down_999", 32'(t_cnt), 32'h999);
        t_en = 0; t_ld = 1; t_lv = 12'h9A9; tick();
        check("d3_bad_cnt", 32'(t_cnt), 32'h000);
        check("d3_bad_err", 32'(t_err), 32'h1);
        t_ld = 0;

        // ---------------- hour instance ----------------
        h_ld = 1; h_lv = 8'h22; tick();
        check("hr_load22", 32'(h_cnt), 32'h22);
        h_ld = 0; h_en = 1; h_up = 1; tick();
        check("hr_up23", 32'(h_cnt), 32'h23);
        #1;
        check("hr_carry23", 32'(h_carry), 32'h1);
        tick();
        check("hr_wrap00", 32'(h_cnt), 32'h00);
        h_en = 0; h_ld = 1; h_lv = 8'h24; tick();
        check("hr_bad_cnt", 32'(h_cnt), 32'h00);
        check("hr_bad_err", 32'(h_err), 32'h1);
        h_ld = 0;

        // ---------------- cascade sec -> min ----------------
        s_ld = 1; s_lv = 8'h58; n_ld = 1; n_lv = 8'h07; tick();
        check("cas_sec58", 32'(s_cnt), 32'h58);
        check("cas_min07", 32'(n_cnt), 32'h07);
        s_ld = 0; n_ld = 0; s_en = 1; #1;
        check("cas_carry58", 32'(s_carry), 32'h0);
        tick();
        check("cas_sec59", 32'(s_cnt), 32'h59);
        check("cas_min_hold", 32'(n_cnt), 32'h07);
        #1;
        check("cas_carry59", 32'(s_carry), 32'h1);
        tick();
        check("cas_sec00", 32'(s_cnt), 32'h00);
        check("cas_min08", 32'(n_cnt), 32'h08);
        s_en = 0; tick();
        check("cas_min_stay", 32'(n_cnt), 32'h08);

        // ---------------- MAX_BCD = 0 ----------------
        z_en = 1; z_up = 1; #1;
        check("z_carry_up", 32'(z_carry), 32'h1);
        tick();
        check("z_cnt_up", 32'(z_cnt), 32'h0);
        z_up = 0; #1;
        check("z_carry_dn", 32'(z_carry), 32'h1);
        tick();
        check("z_cnt_dn", 32'(z_cnt), 32'h0);
        z_en = 0; #1;
        check("z_carry_off", 32'(z_carry), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
